// File: rtl/program_loader_pkg.sv
// Shared constants, state codes and header payload for the program loader.
package program_loader_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned HDR_BYTES = 4;
    localparam int unsigned IBYTES    = 4;
    localparam int unsigned DBYTES    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned IWORD_W   = 8 * IBYTES;
    localparam int unsigned DWORD_W   = 8 * DBYTES;

    localparam logic [STATE_W-1:0] ST_HDR  = 3'd0;
    localparam logic [STATE_W-1:0] ST_IMEM = 3'd1;
    localparam logic [STATE_W-1:0] ST_DMEM = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd4;

    // Little-endian header: icount in the first two bytes, dcount in the next two.
    typedef struct packed {
        logic [CNT_W-1:0] dcount;
        logic [CNT_W-1:0] icount;
    } hdr_t;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready byte stream feeding the program loader.
interface program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects BYTES accepted bytes LSB-first; flags the completing byte combinationally.
module byte_assembler #(
    parameter  int unsigned BYTES  = 4,
    localparam int unsigned DATA_W = 8 * BYTES,
    localparam int unsigned CNT_W  = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_c,
    output logic              word_valid_c
);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;

    // New byte enters at the top so the first byte ends up in bits [7:0].
    assign word_c       = {byte_in, shift_q[DATA_W-1:8]};
    assign word_valid_c = accept && (cnt_q == CNT_W'(BYTES - 1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            shift_q <= word_c;
            cnt_q   <= word_valid_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a byte-stream image into imem/dmem writes, then enables the CPU.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               arst_n,
    program_loader_if.slave    rx,
    output logic [ADDR_W-1:0]  addr_ext,
    output logic               wen_ext,
    output logic               ren_ext,
    output logic [IWORD_W-1:0] wdata_ext,
    output logic [ADDR_W-1:0]  addr_ext_2,
    output logic               wen_ext_2,
    output logic               ren_ext_2,
    output logic [DWORD_W-1:0] wdata_ext_2,
    output logic               cpu_enable,
    output logic               done,
    output logic               error
);

    localparam int unsigned HI_BYTES = (HDR_BYTES > IBYTES) ? HDR_BYTES : IBYTES;

    logic [STATE_W-1:0] state_q, next_state;
    logic               rx_ready_q;
    logic [CNT_W-1:0]   icount_q, dcount_q, idx_q;
    logic               acc, asm_clear;
    logic [IWORD_W-1:0] a_word;
    logic               a_valid;
    logic [DWORD_W-1:0] d_word;
    logic               d_valid;
    logic               iwr, dwr, idx_clr, idx_inc;
    hdr_t               hdr;

    assign acc         = rx.rx_valid && rx_ready_q;
    assign rx.rx_ready = rx_ready_q;
    assign asm_clear   = (state_q == ST_RUN) || (state_q == ST_ERR);
    assign hdr         = hdr_t'(a_word);
    assign ren_ext     = 1'b0;
    assign ren_ext_2   = 1'b0;

    // Header and instruction words share the 4-byte assembler; they never overlap in time.
    byte_assembler #(.BYTES(HI_BYTES)) u_asm_i (
        .clk          (clk),
        .arst_n       (arst_n),
        .clear        (asm_clear),
        .accept       (acc && ((state_q == ST_HDR) || (state_q == ST_IMEM))),
        .byte_in      (rx.rx_data),
        .word_c       (a_word),
        .word_valid_c (a_valid)
    );

    byte_assembler #(.BYTES(DBYTES)) u_asm_d (
        .clk          (clk),
        .arst_n       (arst_n),
        .clear        (asm_clear),
        .accept       (acc && (state_q == ST_DMEM)),
        .byte_in      (rx.rx_data),
        .word_c       (d_word),
        .word_valid_c (d_valid)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= ST_HDR;
        else         state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        iwr        = 1'b0;
        dwr        = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        case (state_q)
            ST_HDR: if (a_valid) begin
                idx_clr = 1'b1;
                if (32'(hdr.icount) > IMEM_WORDS || 32'(hdr.dcount) > DMEM_WORDS)
                    next_state = ST_ERR;
                else if (hdr.icount != '0) next_state = ST_IMEM;
                else if (hdr.dcount != '0) next_state = ST_DMEM;
                else                       next_state = ST_RUN;
            end
            ST_IMEM: if (a_valid) begin
                iwr = 1'b1;
                if (idx_q == icount_q - CNT_W'(1)) begin
                    idx_clr    = 1'b1;
                    next_state = (dcount_q != '0) ? ST_DMEM : ST_RUN;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            ST_DMEM: if (d_valid) begin
                dwr = 1'b1;
                if (idx_q == dcount_q - CNT_W'(1)) begin
                    idx_clr    = 1'b1;
                    next_state = ST_RUN;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            ST_RUN:  next_state = ST_RUN;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_HDR;
        endcase
    end

    // Counters and the item index.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            icount_q <= '0;
            dcount_q <= '0;
            idx_q    <= '0;
        end else begin
            if (state_q == ST_HDR && a_valid) begin
                icount_q <= hdr.icount;
                dcount_q <= hdr.dcount;
            end
            if (idx_clr)      idx_q <= '0;
            else if (idx_inc) idx_q <= idx_q + CNT_W'(1);
        end
    end

    // Registered outputs; addresses and data hold between strobes.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_ready_q  <= 1'b1;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            cpu_enable  <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            rx_ready_q <= (next_state == ST_HDR) || (next_state == ST_IMEM) ||
                          (next_state == ST_DMEM);
            wen_ext    <= iwr;
            wen_ext_2  <= dwr;
            if (iwr) begin
                addr_ext  <= ADDR_W'(idx_q) << 2;
                wdata_ext <= a_word;
            end
            if (dwr) begin
                addr_ext_2  <= ADDR_W'(idx_q) << 3;
                wdata_ext_2 <= d_word;
            end
            cpu_enable <= (state_q == ST_RUN);
            done       <= (state_q == ST_RUN);
            error      <= (next_state == ST_ERR);
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, done, error;

    always #5 clk = ~clk;

    program_loader_if rx_if ();

    program_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rx          (rx_if),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .done        (done),
        .error       (error)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    wr_t  iq[$];
    wr_t  dq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc_cyc = 0;
    int   n = 0;
    logic prev_wi = 1'b0;
    logic prev_wd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: logs strobes, checks one-cycle width and mutual exclusion.
    always @(negedge clk) begin
        if (wen_ext) begin
            chk("iwen_width", 64'(prev_wi), 64'd0);
            chk("wen_exclusive", 64'(wen_ext_2), 64'd0);
            iq.push_back('{addr_ext, 64'(wdata_ext), cyc});
        end
        if (wen_ext_2) begin
            chk("dwen_width", 64'(prev_wd), 64'd0);
            dq.push_back('{addr_ext_2, wdata_ext_2, cyc});
        end
        prev_wi = wen_ext;
        prev_wd = wen_ext_2;
    end

    // Called at a negedge; returns at the negedge after the byte is consumed.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        if (gap > 0) begin
            rx_if.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        w = 0;
        while (!rx_if.rx_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rx_if.rx_ready) chk("accept_timeout", 64'(rx_if.rx_ready), 64'd1);
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [63:0] wd, input int nbytes, input int maxgap);
        for (int i = 0; i < nbytes; i++)
            send_byte(wd[8*i +: 8], int'($urandom_range(0, maxgap)));
    endtask

    task automatic apply_reset();
        rx_if.rx_valid = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        iq.delete();
        dq.delete();
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        // Reset values
        chk("rst_rx_ready", 64'(rx_if.rx_ready), 64'd1);
        chk("rst_wen", 64'(wen_ext), 64'd0);
        chk("rst_addr", addr_ext, 64'd0);
        chk("rst_wdata", 64'(wdata_ext), 64'd0);
        chk("rst_wen2", 64'(wen_ext_2), 64'd0);
        chk("rst_addr2", addr_ext_2, 64'd0);
        chk("rst_wdata2", wdata_ext_2, 64'd0);
        chk("rst_ren", 64'({ren_ext, ren_ext_2}), 64'd0);
        chk("rst_flags", 64'({cpu_enable, done, error}), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Basic load: 2 instructions, 1 doubleword
        apply_reset();
        send_word(64'h0001_0002, 4, 0);
        send_word(64'h0050_0093, 4, 0);
        send_word(64'h0010_0113, 4, 0);
        send_word(64'h1122_3344_5566_7788, 8, 0);
        rx_if.rx_valid = 1'b0;
        n = acc_cyc;
        chk("basic_n1_wen2", 64'(wen_ext_2), 64'd1);
        chk("basic_n1_cpu_en", 64'(cpu_enable), 64'd0);
        chk("basic_n1_done", 64'(done), 64'd0);
        chk("basic_n1_ready", 64'(rx_if.rx_ready), 64'd0);
        @(negedge clk);
        chk("basic_n2_cpu_en", 64'(cpu_enable), 64'd1);
        chk("basic_n2_done", 64'(done), 64'd1);
        chk("basic_error", 64'(error), 64'd0);
        chk("basic_icnt", 64'(iq.size()), 64'd2);
        chk("basic_i0_addr", iq[0].addr, 64'd0);
        chk("basic_i0_data", iq[0].data, 64'h0050_0093);
        chk("basic_i1_addr", iq[1].addr, 64'd4);
        chk("basic_i1_data", iq[1].data, 64'h0010_0113);
        chk("basic_i_spacing", 64'(iq[1].cyc - iq[0].cyc), 64'd4);
        chk("basic_dcnt", 64'(dq.size()), 64'd1);
        chk("basic_d0_addr", dq[0].addr, 64'd0);
        chk("basic_d0_data", dq[0].data, 64'h1122_3344_5566_7788);
        chk("basic_d0_latency", 64'(dq[0].cyc - n), 64'd1);

        // Empty image
        apply_reset();
        send_word(64'h0, 4, 0);
        rx_if.rx_valid = 1'b0;
        chk("empty_n1_cpu_en", 64'(cpu_enable), 64'd0);
        @(negedge clk);
        chk("empty_n2_cpu_en", 64'(cpu_enable), 64'd1);
        chk("empty_n2_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("empty_no_writes", 64'(iq.size() + dq.size()), 64'd0);

        // Overflow: icount = 513
        apply_reset();
        send_word(64'h0000_0201, 4, 0);
        rx_if.rx_valid = 1'b0;
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_ready", 64'(rx_if.rx_ready), 64'd0);
        rx_if.rx_data  = 8'h55;
        rx_if.rx_valid = 1'b1;
        repeat (12) @(negedge clk);
        rx_if.rx_valid = 1'b0;
        chk("ovf_no_writes", 64'(iq.size() + dq.size()), 64'd0);
        chk("ovf_flags", 64'({cpu_enable, done, error}), 64'b001);

        // dcount = 1025 rejected; icount = 512 accepted
        apply_reset();
        send_word(64'h0401_0000, 4, 0);
        rx_if.rx_valid = 1'b0;
        chk("dovf_error", 64'(error), 64'd1);
        apply_reset();
        send_word(64'h0000_0200, 4, 0);
        rx_if.rx_valid = 1'b0;
        chk("imax_error", 64'(error), 64'd0);
        chk("imax_ready", 64'(rx_if.rx_ready), 64'd1);

        // Random gaps over icount = 3
        apply_reset();
        send_word(64'h0000_0003, 4, 5);
        send_word(64'hDEAD_BEEF, 4, 5);
        send_word(64'h0123_4567, 4, 5);
        send_word(64'h89AB_CDEF, 4, 5);
        rx_if.rx_valid = 1'b0;
        @(negedge clk);
        chk("gap_icnt", 64'(iq.size()), 64'd3);
        chk("gap_i0", {iq[0].addr[31:0], iq[0].data[31:0]}, 64'h0000_0000_DEAD_BEEF);
        chk("gap_i1", {iq[1].addr[31:0], iq[1].data[31:0]}, 64'h0000_0004_0123_4567);
        chk("gap_i2", {iq[2].addr[31:0], iq[2].data[31:0]}, 64'h0000_0008_89AB_CDEF);
        chk("gap_done", 64'(done), 64'd1);

        // Reset mid-load after 2 bytes of word 1
        apply_reset();
        send_word(64'h0000_0002, 4, 0);
        send_word(64'hA5A5_A5A5, 4, 0);
        send_word(64'h0000_3C3C, 2, 0);
        rx_if.rx_valid = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 64'(rx_if.rx_ready), 64'd1);
        chk("mid_rst_wdata", 64'(wdata_ext), 64'd0);
        iq.delete();
        arst_n = 1'b1;
        @(negedge clk);
        send_word(64'h0000_0001, 4, 0);
        send_word(64'hCAFE_F00D, 4, 0);
        rx_if.rx_valid = 1'b0;
        @(negedge clk);
        chk("mid_icnt", 64'(iq.size()), 64'd1);
        chk("mid_i0_addr", iq[0].addr, 64'd0);
        chk("mid_i0_data", iq[0].data, 64'hCAFE_F00D);
        chk("mid_done", 64'(done), 64'd1);

        // Back-to-back, icount = 4, dcount = 0
        apply_reset();
        send_word(64'h0000_0004, 4, 0);
        for (int k = 0; k < 4; k++) send_word(64'h1111_1111 * 64'(k + 1), 4, 0);
        rx_if.rx_valid = 1'b0;
        @(negedge clk);
        chk("b2b_icnt", 64'(iq.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk("b2b_addr", iq[k].addr, 64'(4 * k));
            chk("b2b_data", iq[k].data, 64'h1111_1111 * 64'(k + 1));
            if (k > 0) chk("b2b_spacing", 64'(iq[k].cyc - iq[k-1].cyc), 64'd4);
        end
        chk("b2b_no_dwrites", 64'(dq.size()), 64'd0);
        chk("b2b_done", 64'(done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
